// File: rtl/status_stack.sv
// Condition-flag register with masked writes and a nested interrupt save/restore stack.
// Define STATUS_STACK_WRAP_EN to make the stack circular (a save while full overwrites the oldest context).
module status_stack #(
   parameter int                FLAG_W    = 3,
   parameter int                DEPTH     = 4,
   parameter logic [FLAG_W-1:0] CLEAR_VAL = {FLAG_W{1'b0}}
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wreg,
   input  logic [FLAG_W-1:0]          flags_in,
   input  logic [FLAG_W-1:0]          wmask,
   input  logic                       int_save,
   input  logic                       int_load,
   input  logic                       err_clr,
   output logic [FLAG_W-1:0]          flags,
   output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
   output logic                       stack_full,
   output logic                       stack_empty,
   output logic                       ovf_err,
   output logic                       unf_err
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? PTR_ZERO : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == PTR_ZERO) ? PTR_LAST : p - PTR_W'(1);
   endfunction

   // head_r is the next slot to write; the top of stack sits one below it (mod DEPTH)
   logic [FLAG_W-1:0] stack_r [DEPTH];
   logic [FLAG_W-1:0] flags_r, flags_nxt_s, merged_s;
   logic [CNT_W-1:0]  depth_r, depth_nxt_s;
   logic [PTR_W-1:0]  head_r, head_nxt_s;
   logic              ovf_r, unf_r, ovf_set_s, unf_set_s, push_s;
   logic              full_s, empty_s;

   assign full_s      = (depth_r == CNT_FULL);
   assign empty_s     = (depth_r == {CNT_W{1'b0}});
   assign flags       = flags_r;
   assign depth_cnt   = depth_r;
   assign stack_full  = full_s;
   assign stack_empty = empty_s;
   assign ovf_err     = ovf_r;
   assign unf_err     = unf_r;

   // Next-state decode: save beats load beats plain write
   always_comb begin
      merged_s    = wreg ? ((flags_r & ~wmask) | (flags_in & wmask)) : flags_r;
      flags_nxt_s = merged_s;
      depth_nxt_s = depth_r;
      head_nxt_s  = head_r;
      push_s      = 1'b0;
      ovf_set_s   = 1'b0;
      unf_set_s   = 1'b0;
      if (int_save) begin
         if (!full_s) begin
            push_s      = 1'b1;
            flags_nxt_s = CLEAR_VAL;
            depth_nxt_s = depth_r + CNT_ONE;
            head_nxt_s  = ptr_inc(head_r);
         end else begin
            ovf_set_s   = 1'b1;
`ifdef STATUS_STACK_WRAP_EN
            // When full, head_r points at the oldest context, which gets overwritten
            push_s      = 1'b1;
            flags_nxt_s = CLEAR_VAL;
            head_nxt_s  = ptr_inc(head_r);
`else
            flags_nxt_s = merged_s;
`endif
         end
      end else if (int_load) begin
         if (!empty_s) begin
            flags_nxt_s = stack_r[ptr_dec(head_r)];
            depth_nxt_s = depth_r - CNT_ONE;
            head_nxt_s  = ptr_dec(head_r);
         end else begin
            unf_set_s   = 1'b1;
         end
      end else begin
         flags_nxt_s = merged_s;
      end
   end

   // Flag, depth, pointer and sticky-error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= {FLAG_W{1'b0}};
         depth_r <= {CNT_W{1'b0}};
         head_r  <= PTR_ZERO;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         flags_r <= flags_nxt_s;
         depth_r <= depth_nxt_s;
         head_r  <= head_nxt_s;
         ovf_r   <= ovf_set_s | (ovf_r & ~err_clr);
         unf_r   <= unf_set_s | (unf_r & ~err_clr);
      end
   end

   // Save-stack storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_r[i] <= {FLAG_W{1'b0}};
         end
      end else if (push_s) begin
         stack_r[head_r] <= merged_s;
      end else begin
         stack_r[head_r] <= stack_r[head_r];
      end
   end

endmodule

// File: tb/tb_status_stack.sv
// Directed self-checking bench for status_stack (FLAG_W=3, DEPTH=4).
// Expectations follow STATUS_STACK_WRAP_EN when it is defined for the build.
module tb_status_stack;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wreg, int_save, int_load, err_clr;
   logic [2:0] flags_in, wmask;
   logic [2:0] flags;
   logic [2:0] depth_cnt;
   logic       stack_full, stack_empty, ovf_err, unf_err;

   int tests_run = 0;
   int tests_failed = 0;

   status_stack #(.FLAG_W(3), .DEPTH(4), .CLEAR_VAL(3'b000)) dut (
      .clk(clk), .rst_n(rst_n), .wreg(wreg), .flags_in(flags_in), .wmask(wmask),
      .int_save(int_save), .int_load(int_load), .err_clr(err_clr),
      .flags(flags), .depth_cnt(depth_cnt), .stack_full(stack_full),
      .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs at a negedge, clock it, return at the next negedge
   task automatic cyc(input logic wr, input logic [2:0] msk, input logic [2:0] fin,
                      input logic sv, input logic ld, input logic ec);
      wreg = wr; wmask = msk; flags_in = fin;
      int_save = sv; int_load = ld; err_clr = ec;
      @(posedge clk);
      @(negedge clk);
      wreg = 1'b0; wmask = 3'b000; flags_in = 3'b000;
      int_save = 1'b0; int_load = 1'b0; err_clr = 1'b0;
   endtask

   logic [2:0] push_vals [4];
   logic [2:0] pop_vals  [4];

   initial begin
      push_vals[0] = 3'b001; push_vals[1] = 3'b010;
      push_vals[2] = 3'b011; push_vals[3] = 3'b100;
`ifdef STATUS_STACK_WRAP_EN
      pop_vals[0] = 3'b101; pop_vals[1] = 3'b100;
      pop_vals[2] = 3'b011; pop_vals[3] = 3'b010;
`else
      pop_vals[0] = 3'b100; pop_vals[1] = 3'b011;
      pop_vals[2] = 3'b010; pop_vals[3] = 3'b001;
`endif
      rst_n = 1'b0;
      wreg = 1'b0; wmask = 3'b000; flags_in = 3'b000;
      int_save = 1'b0; int_load = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_flags", 32'(flags), 32'd0);
      check_val("rst_depth", 32'(depth_cnt), 32'd0);
      check_val("rst_empty", 32'(stack_empty), 32'd1);
      check_val("rst_full", 32'(stack_full), 32'd0);
      check_val("rst_ovf", 32'(ovf_err), 32'd0);
      check_val("rst_unf", 32'(unf_err), 32'd0);
      rst_n = 1'b1;

      // Masked write
      cyc(1'b1, 3'b101, 3'b111, 1'b0, 1'b0, 1'b0);
      check_val("mask_flags", 32'(flags), 32'h5);
      check_val("mask_depth", 32'(depth_cnt), 32'd0);
      check_val("mask_empty", 32'(stack_empty), 32'd1);

      // Save with same-cycle write, then restore
      cyc(1'b1, 3'b111, 3'b010, 1'b0, 1'b0, 1'b0);
      check_val("pre_save_flags", 32'(flags), 32'h2);
      cyc(1'b1, 3'b111, 3'b110, 1'b1, 1'b0, 1'b0);
      check_val("save_flags", 32'(flags), 32'h0);
      check_val("save_depth", 32'(depth_cnt), 32'd1);
      cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
      check_val("load_flags", 32'(flags), 32'h6);
      check_val("load_depth", 32'(depth_cnt), 32'd0);

      // Nest to DEPTH
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 3'b111, push_vals[i], 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
         check_val("nest_depth", 32'(depth_cnt), 32'(i + 1));
      end
      check_val("nest_full", 32'(stack_full), 32'd1);
      check_val("nest_ovf", 32'(ovf_err), 32'd0);

      // Save while full
      cyc(1'b1, 3'b111, 3'b101, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      check_val("ovf_err", 32'(ovf_err), 32'd1);
      check_val("ovf_depth", 32'(depth_cnt), 32'd4);
`ifdef STATUS_STACK_WRAP_EN
      check_val("ovf_flags", 32'(flags), 32'h0);
`else
      check_val("ovf_flags", 32'(flags), 32'h5);
`endif

      // LIFO unwind
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
         check_val("lifo_flags", 32'(flags), 32'(pop_vals[i]));
      end
      check_val("lifo_empty", 32'(stack_empty), 32'd1);
      check_val("ovf_sticky", 32'(ovf_err), 32'd1);
      check_val("lifo_unf", 32'(unf_err), 32'd0);
      cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
      check_val("ovf_clr", 32'(ovf_err), 32'd0);

      // Underflow and error clear
      cyc(1'b1, 3'b111, 3'b011, 1'b0, 1'b1, 1'b0);
      check_val("unf_err", 32'(unf_err), 32'd1);
      check_val("unf_flags", 32'(flags), 32'h3);
      check_val("unf_depth", 32'(depth_cnt), 32'd0);
      cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
      check_val("unf_clr", 32'(unf_err), 32'd0);
      cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);
      check_val("unf_set_wins", 32'(unf_err), 32'd1);
      cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);

      // Simultaneous save and load
      cyc(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
      check_val("sim_pre_depth", 32'(depth_cnt), 32'd1);
      cyc(1'b1, 3'b111, 3'b111, 1'b1, 1'b1, 1'b0);
      check_val("sim_depth", 32'(depth_cnt), 32'd2);
      check_val("sim_unf", 32'(unf_err), 32'd0);
      check_val("sim_flags", 32'(flags), 32'h0);
      cyc(1'b1, 3'b111, 3'b110, 1'b0, 1'b0, 1'b0);
      check_val("pre_rst_flags", 32'(flags), 32'h6);

      // Async reset between edges
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_flags", 32'(flags), 32'd0);
      check_val("arst_depth", 32'(depth_cnt), 32'd0);
      check_val("arst_empty", 32'(stack_empty), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
      check_val("post_rst_unf", 32'(unf_err), 32'd1);
      check_val("post_rst_flags", 32'(flags), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/status_stack.md
Name: status_stack

Overview:
- Parametrised condition-flag register with a nested interrupt save/restore stack.
- Replaces the single-level flag save of the current processor datapath, so interrupts can nest up to DEPTH levels.
- Sits between the ALU flag outputs and the control unit; the control unit asserts int_save on interrupt entry and int_load on return.
- Adds per-flag write masking plus sticky overflow/underflow error reporting.

Parameters:
- FLAG_W, 3, number of flag bits; default bit order is bit2=N, bit1=Z, bit0=C.
- DEPTH, 4, number of save-stack entries (>=1).
- CLEAR_VAL, 0, value loaded into flags on a successful save (flags on interrupt entry).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wreg  in  1  flag write enable.
- flags_in  in  FLAG_W  new flag values from the ALU.
- wmask  in  FLAG_W  per-bit write mask; 1 = bit updated by wreg.
- int_save  in  1  push current flags onto the stack, then load CLEAR_VAL.
- int_load  in  1  pop the top of stack into flags.
- err_clr  in  1  clear sticky error bits.
- flags  out  FLAG_W  current flag register.
- depth_cnt  out  $clog2(DEPTH+1)  number of occupied stack entries.
- stack_full  out  1  depth_cnt==DEPTH, combinational from state.
- stack_empty  out  1  depth_cnt==0, combinational from state.
- ovf_err  out  1  sticky; a save was attempted while full.
- unf_err  out  1  sticky; a load was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - flags=0, depth_cnt=0, all stack entries=0, ovf_err=0, unf_err=0.
  - A reset mid-nesting discards all saved contexts.
- Merged value:
  - merged = wreg ? (flags & ~wmask) | (flags_in & wmask) : flags.
- Priority per cycle: int_save > int_load > plain wreg.
  - If int_save and int_load are both high, the load is ignored and no error is raised for it.
- Successful save (int_save, not full):
  - stack[depth_cnt] <= merged (the same-cycle wreg update is saved).
  - flags <= CLEAR_VAL; depth_cnt += 1.
  - Result is visible on the next cycle; latency 1.
- Successful load (int_load, no save, not empty):
  - flags <= stack[depth_cnt-1]; depth_cnt -= 1.
  - A wreg in the same cycle is ignored.
- Save while full (without the optional feature):
  - ovf_err <= 1; stack and depth_cnt are unchanged.
  - flags <= merged, i.e. the save is dropped and the wreg update still applies.
- Load while empty:
  - unf_err <= 1; depth_cnt stays 0; flags <= merged.
- No save or load: flags <= merged.
- Sticky errors:
  - err_clr clears ovf_err and unf_err.
  - If a new error occurs in the same cycle as err_clr, the set wins.
- Stack slots above depth_cnt keep stale data; it is not observable.

Optional Feature:
- Macro: STATUS_STACK_WRAP_EN.
- Defined:
  - Stack is circular: a save while full overwrites the oldest entry.
  - flags <= CLEAR_VAL and depth_cnt stays DEPTH.
  - ovf_err is still set (sticky) to flag the lost context.
  - Subsequent loads return the newest DEPTH contexts in LIFO order.
  - Requires a head pointer modulo DEPTH.
- Undefined: saves while full are dropped as described in Behaviour.

Test Plan:
- Reset and masked write:
  - Release rst_n.
  - wreg=1, wmask=3'b101, flags_in=3'b111 -> flags=3'b101 next cycle; depth_cnt=0, stack_empty=1.
- Save with same-cycle write, then restore:
  - flags=3'b010; in one cycle wreg=1, wmask=3'b111, flags_in=3'b110, int_save=1 -> flags=3'b000, depth_cnt=1.
  - int_load -> flags=3'b110, depth_cnt=0.
- Nesting to DEPTH=4 and LIFO order:
  - Save four times with flags 3'b001, 3'b010, 3'b011, 3'b100 -> stack_full=1.
  - Four loads -> flags go 3'b100, 3'b011, 3'b010, 3'b001, then stack_empty=1.
- Overflow, macro undefined:
  - Full stack, flags=3'b101, int_save=1 -> ovf_err=1, depth_cnt=4, flags=3'b101.
  - With the macro defined instead: flags=3'b000, and four loads return the newest four contexts.
- Underflow and error clear:
  - Empty stack, int_load=1, wreg=1, wmask=3'b111, flags_in=3'b011 -> unf_err=1, flags=3'b011.
  - err_clr=1 -> unf_err=0.
  - err_clr together with a new empty load -> unf_err stays 1.
- Simultaneous save/load and async reset:
  - int_save=int_load=1 with depth_cnt=1 -> depth_cnt=2, no unf_err.
  - Drop rst_n between clock edges with depth_cnt=2 -> flags=0 and depth_cnt=0 immediately, without a clock edge.
